// File: rtl/ase_tx_port_arbiter.sv
// Packet-aware round-robin arbiter: merges NUM_PORTS AXI-Stream TX sources onto one
// link, holding the grant for a whole packet, through a single registered output stage.
module ase_tx_port_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned USER_W    = 10
) (
  input  logic                          pClk,
  input  logic                          softReset,
  input  logic [NUM_PORTS-1:0]          in_tvalid,
  output logic [NUM_PORTS-1:0]          in_tready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_tdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] in_tkeep,
  input  logic [NUM_PORTS*USER_W-1:0]   in_tuser,
  input  logic [NUM_PORTS-1:0]          in_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [DATA_W-1:0]             out_tdata,
  output logic [DATA_W/8-1:0]           out_tkeep,
  output logic [USER_W-1:0]             out_tuser,
  output logic                          out_tlast,
  output logic [$clog2(NUM_PORTS)-1:0]  out_port,
  output logic [31:0]                   pkt_count
);

  localparam int unsigned PORT_W = $clog2(NUM_PORTS);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic [PORT_W-1:0]   owner_q, owner_d;
  logic                out_tvalid_q, out_tvalid_d;
  logic [DATA_W-1:0]   out_tdata_q, out_tdata_d;
  logic [KEEP_W-1:0]   out_tkeep_q, out_tkeep_d;
  logic [USER_W-1:0]   out_tuser_q, out_tuser_d;
  logic                out_tlast_q, out_tlast_d;
  logic [PORT_W-1:0]   out_port_q, out_port_d;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;

  logic [PORT_W-1:0]   idx;
  logic [PORT_W-1:0]   cand;
  logic                cand_vld;
  logic [PORT_W-1:0]   grant;
  logic                grant_vld;
  logic                can_accept;
  logic                xfer;
  logic                sel_valid;
  logic                sel_last;

  logic [DATA_W-1:0]   data_a [NUM_PORTS];
  logic [KEEP_W-1:0]   keep_a [NUM_PORTS];
  logic [USER_W-1:0]   user_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign data_a[g] = in_tdata[g*DATA_W +: DATA_W];
    assign keep_a[g] = in_tkeep[g*KEEP_W +: KEEP_W];
    assign user_a[g] = in_tuser[g*USER_W +: USER_W];
  end

  // Circular search for the first requester after the last granted port
  always_comb begin
    idx      = '0;
    cand     = ptr_q;
    cand_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_W'((32'(ptr_q) + i) % NUM_PORTS);
      if (!cand_vld && in_tvalid[idx]) begin
        cand     = idx;
        cand_vld = 1'b1;
      end
    end
  end

  always_comb begin
    can_accept = !out_tvalid_q || out_tready;
    grant      = (state_q == ST_LOCKED) ? owner_q : cand;
    grant_vld  = (state_q == ST_LOCKED) || cand_vld;
    sel_valid  = in_tvalid[grant];
    sel_last   = in_tlast[grant];
    in_tready  = '0;
    if (grant_vld && can_accept && !softReset) begin
      in_tready = NUM_PORTS'(1) << grant;
    end
    xfer = grant_vld && can_accept && !softReset && sel_valid;
  end

  // Grant state: hold the owner from first beat through tlast
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          ptr_d   = grant;
          owner_d = grant;
          if (!sel_last) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer && sel_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage and packet counter
  always_comb begin
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tuser_d  = out_tuser_q;
    out_tlast_d  = out_tlast_q;
    out_port_d   = out_port_q;
    pkt_count_d  = pkt_count_q;
    if (xfer) begin
      out_tvalid_d = 1'b1;
      out_tdata_d  = data_a[grant];
      out_tkeep_d  = keep_a[grant];
      out_tuser_d  = user_a[grant];
      out_tlast_d  = sel_last;
      out_port_d   = grant;
    end else if (out_tready) begin
      out_tvalid_d = 1'b0;
    end
    if (out_tvalid_q && out_tready && out_tlast_q) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pClk) begin
    if (softReset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PORT_W'(NUM_PORTS - 1);
      owner_q      <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tuser_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_port_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tuser_q  <= out_tuser_d;
      out_tlast_q  <= out_tlast_d;
      out_port_q   <= out_port_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_tuser  = out_tuser_q;
  assign out_tlast  = out_tlast_q;
  assign out_port   = out_port_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_ase_tx_port_arbiter.sv
// Bench for ase_tx_port_arbiter: per-port packet sources, a cycle-level arbitration
// model and a per-port scoreboard, exercised by directed and randomized scenarios.
module tb_ase_tx_port_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned UW = 10;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned PW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic             pClk = 1'b0;
  logic             softReset = 1'b1;
  logic [NP-1:0]    in_tvalid = '0;
  logic [NP-1:0]    in_tready;
  logic [NP*DW-1:0] in_tdata = '0;
  logic [NP*KW-1:0] in_tkeep = '0;
  logic [NP*UW-1:0] in_tuser = '0;
  logic [NP-1:0]    in_tlast = '0;
  logic             out_tvalid;
  logic             out_tready = 1'b0;
  logic [DW-1:0]    out_tdata;
  logic [KW-1:0]    out_tkeep;
  logic [UW-1:0]    out_tuser;
  logic             out_tlast;
  logic [PW-1:0]    out_port;
  logic [31:0]      pkt_count;

  ase_tx_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW)) dut (
    .pClk(pClk), .softReset(softReset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_port(out_port), .pkt_count(pkt_count)
  );

  always #5 pClk = ~pClk;

  int errors = 0;
  int checks = 0;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  bit    hold  [NP];
  bit    rst_req = 1'b1;
  bit    otr_req = 1'b0;

  // Reference model of the link as seen from outside
  bit          m_valid = 1'b0;
  beat_t       m_beat = '0;
  int          m_port = 0;
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  int          m_ptr = NP - 1;
  logic [31:0] m_cnt = '0;
  logic [NP-1:0] m_rdy = '0;
  int          m_g = -1;

  function automatic beat_t rand_beat(bit last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
    b.keep = {$urandom, $urandom};
    b.user = UW'($urandom);
    b.last = last;
    return b;
  endfunction

  task automatic load_pkt(int p, int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat(i == n - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic flush_sources();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      hold[p] = 1'b0;
    end
  endtask

  task automatic drive();
    softReset  = rst_req;
    out_tready = otr_req;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        in_tvalid[p] = !hold[p];
        in_tdata[p*DW +: DW] = src_q[p][0].data;
        in_tkeep[p*KW +: KW] = src_q[p][0].keep;
        in_tuser[p*UW +: UW] = src_q[p][0].user;
        in_tlast[p] = src_q[p][0].last;
      end else begin
        in_tvalid[p] = 1'b0;
        in_tlast[p]  = 1'b0;
      end
    end
  endtask

  // Which port the rules say may move a beat this cycle
  task automatic model_expect();
    bit can;
    m_rdy = '0;
    m_g   = -1;
    if (!softReset) begin
      can = !m_valid || out_tready;
      if (m_locked) m_g = m_owner;
      else
        for (int k = 1; k <= NP; k++)
          if (m_g < 0 && in_tvalid[(m_ptr + k) % NP]) m_g = (m_ptr + k) % NP;
      if (can && m_g >= 0) m_rdy[m_g] = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (softReset) begin
      m_valid = 1'b0; m_beat = '0; m_port = 0;
      m_locked = 1'b0; m_ptr = NP - 1; m_cnt = '0;
    end else begin
      if (m_valid && out_tready && m_beat.last) m_cnt = m_cnt + 32'd1;
      if (m_g >= 0 && m_rdy[m_g] && in_tvalid[m_g]) begin
        m_beat   = src_q[m_g].pop_front();
        m_valid  = 1'b1;
        m_port   = m_g;
        m_ptr    = m_g;
        m_owner  = m_g;
        m_locked = !m_beat.last;
      end else if (out_tready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge pClk);
    model_edge();
    @(negedge pClk);
    drive();
    #1;
    model_expect();
  endtask

  task automatic apply_reset();
    rst_req = 1'b1;
    otr_req = 1'b1;
    flush_sources();
    step();
    step();
    rst_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_req = 1'b1;
    otr_req = 1'b1;
    for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) load_pkt(p, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (in_tready !== 4'b0000) begin
        errors++; $display("FAIL reset_tready: got %b want 0000", in_tready);
      end
      checks++;
      if (out_tvalid !== 1'b0 || pkt_count !== 32'd0) begin
        errors++; $display("FAIL reset_out: got valid=%b cnt=%0d want valid=0 cnt=0", out_tvalid, pkt_count);
      end
    end
    rst_req = 1'b0;
    step();
    checks++;
    if (in_tready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", in_tready);
    end
    step();
    checks++;
    if (out_tvalid !== 1'b1 || out_port !== 2'd0) begin
      errors++; $display("FAIL reset_first_beat: got valid=%b port=%0d want valid=1 port=0", out_tvalid, out_port);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] want;
    apply_reset();
    for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) load_pkt(p, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      want = NP'(1) << ((k - 1) % NP);
      checks++;
      if (in_tready !== want) begin
        errors++; $display("FAIL rr_tready k=%0d: got %b want %b", k, in_tready, want);
      end
      if (k >= 2) begin
        checks++;
        if (out_tvalid !== 1'b1 || out_port !== PW'((k - 2) % NP) || out_tdata !== m_beat.data) begin
          errors++; $display("FAIL rr_beat k=%0d: got valid=%b port=%0d want valid=1 port=%0d", k, out_tvalid, out_port, (k - 2) % NP);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd8) begin
      errors++; $display("FAIL rr_pkt_count: got %0d want 8", pkt_count);
    end
  endtask

  task automatic test_packet_lock();
    int seen[$];
    logic [NP-1:0] want;
    apply_reset();
    load_pkt(1, 4);
    load_pkt(2, 1);
    hold[2] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) hold[2] = 1'b0;
      step();
      if (out_tvalid && out_tready) seen.push_back(int'(out_port));
      want = (c < 4) ? 4'b0010 : (c == 4) ? 4'b0100 : 4'b0000;
      checks++;
      if (in_tready !== want) begin
        errors++; $display("FAIL lock_tready c=%0d: got %b want %b", c, in_tready, want);
      end
    end
    checks++;
    if (seen.size() != 5 || seen[0] != 1 || seen[1] != 1 || seen[2] != 1 || seen[3] != 1 || seen[4] != 2) begin
      errors++; $display("FAIL lock_order: got %p want '{1,1,1,1,2}", seen);
    end
  endtask

  task automatic test_backpressure();
    beat_t cur, prev, want;
    bit    prev_hold;
    int    left;
    apply_reset();
    for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) load_pkt(p, int'($urandom_range(1, 5)));
    prev_hold = 1'b0;
    prev = '0;
    for (int c = 0; c < 300; c++) begin
      otr_req = (c >= 10 && c < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
      cur = {out_tdata, out_tkeep, out_tuser, out_tlast};
      checks++;
      if (in_tready !== m_rdy) begin
        errors++; $display("FAIL bp_tready c=%0d: got %b want %b", c, in_tready, m_rdy);
      end
      checks++;
      if (out_tvalid !== m_valid || out_port !== PW'(m_port) || cur !== m_beat || pkt_count !== m_cnt) begin
        errors++; $display("FAIL bp_model c=%0d: got valid=%b port=%0d last=%b cnt=%0d want valid=%b port=%0d last=%b cnt=%0d",
                           c, out_tvalid, out_port, out_tlast, pkt_count, m_valid, m_port, m_beat.last, m_cnt);
      end
      if (prev_hold) begin
        checks++;
        if (out_tvalid !== 1'b1 || cur !== prev) begin
          errors++; $display("FAIL bp_stable c=%0d: got valid=%b data[31:0]=%h want held data[31:0]=%h", c, out_tvalid, out_tdata[31:0], prev.data[31:0]);
        end
      end
      if (out_tvalid && !out_tready) begin
        checks++;
        if (in_tready !== 4'b0000) begin
          errors++; $display("FAIL bp_block c=%0d: got %b want 0000", c, in_tready);
        end
      end
      if (out_tvalid && out_tready) begin
        checks++;
        if (exp_q[out_port].size() == 0) begin
          errors++; $display("FAIL sb_extra: got beat from port %0d want none", out_port);
        end else begin
          want = exp_q[out_port].pop_front();
          if (cur !== want) begin
            errors++; $display("FAIL sb_beat port %0d: got data[31:0]=%h last=%b want data[31:0]=%h last=%b",
                               out_port, out_tdata[31:0], out_tlast, want.data[31:0], want.last);
          end
        end
      end
      prev_hold = out_tvalid && !out_tready;
      prev = cur;
      left = 0;
      for (int p = 0; p < NP; p++) left += exp_q[p].size();
      if (left == 0 && c > 15) break;
    end
    checks++;
    if (left != 0) begin
      errors++; $display("FAIL bp_drain: got %0d beats undelivered want 0", left);
    end
  endtask

  task automatic test_owner_stall();
    int seen[$];
    int stall;
    apply_reset();
    load_pkt(3, 4);
    load_pkt(0, 1);
    hold[0] = 1'b1;
    stall = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) hold[0] = 1'b0;
      if (src_q[3].size() == 2 && stall < 3) begin
        hold[3] = 1'b1;
        stall++;
      end else begin
        hold[3] = 1'b0;
      end
      step();
      if (out_tvalid && out_tready) seen.push_back(int'(out_port));
      checks++;
      if (in_tready !== m_rdy) begin
        errors++; $display("FAIL stall_tready c=%0d: got %b want %b", c, in_tready, m_rdy);
      end
      if (src_q[3].size() > 0) begin
        checks++;
        if (in_tready[0] !== 1'b0) begin
          errors++; $display("FAIL stall_block c=%0d: got tready0=%b want 0", c, in_tready[0]);
        end
      end
    end
    checks++;
    if (seen.size() != 5 || seen[0] != 3 || seen[1] != 3 || seen[2] != 3 || seen[3] != 3 || seen[4] != 0) begin
      errors++; $display("FAIL stall_order: got %p want '{3,3,3,3,0}", seen);
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    step();
    release dut.pkt_count_q;
    m_cnt = 32'hFFFF_FFFF;
    load_pkt(1, 1);
    step();
    step();
    checks++;
    if (pkt_count !== 32'hFFFF_FFFF || out_tvalid !== 1'b1 || out_tlast !== 1'b1) begin
      errors++; $display("FAIL wrap_pre: got cnt=%h valid=%b last=%b want cnt=ffffffff valid=1 last=1", pkt_count, out_tvalid, out_tlast);
    end
    step();
    checks++;
    if (pkt_count !== 32'd0) begin
      errors++; $display("FAIL wrap_post: got %h want 00000000", pkt_count);
    end
    load_pkt(2, 6);
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (out_tvalid !== 1'b1 || out_port !== 2'd2 || out_tlast !== 1'b0) begin
      errors++; $display("FAIL midpkt: got valid=%b port=%0d last=%b want valid=1 port=2 last=0", out_tvalid, out_port, out_tlast);
    end
    rst_req = 1'b1;
    flush_sources();
    step();
    step();
    checks++;
    if (out_tvalid !== 1'b0 || in_tready !== 4'b0000 || pkt_count !== 32'd0) begin
      errors++; $display("FAIL midpkt_reset: got valid=%b tready=%b cnt=%0d want valid=0 tready=0000 cnt=0", out_tvalid, in_tready, pkt_count);
    end
    rst_req = 1'b0;
    load_pkt(0, 1);
    load_pkt(2, 1);
    step();
    checks++;
    if (in_tready !== 4'b0001) begin
      errors++; $display("FAIL post_reset_grant: got %b want 0001", in_tready);
    end
    step();
    checks++;
    if (out_tvalid !== 1'b1 || out_port !== 2'd0 || in_tready !== 4'b0100) begin
      errors++; $display("FAIL post_reset_beat: got valid=%b port=%0d tready=%b want valid=1 port=0 tready=0100", out_tvalid, out_port, in_tready);
    end
  endtask

  initial begin
    flush_sources();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_owner_stall();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
